bcd_time_counter: RTL and testbench

//  Consumes the slow square wave from clock_div (clk_out, 1 Hz on board) and keeps an MM:SS BCD time.

---
 rtl/bcd_time_counter.sv | 127 ++++++++++++
 tb/tb_bcd_time_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// MM:SS BCD time counter driven by a slow asynchronous tick, resynchronised to clk_in.
// Optional HH:MM:SS mode (hours 00..23) is enabled by defining TIME_HOURS_EN.
module bcd_time_counter #(
    parameter int SYNC_STAGES = 2,
    parameter bit TICK_EDGE   = 1'b1
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       tick_in,
    input  logic       run,
    input  logic       clear,
    output logic       tick_pulse,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       rollover
`ifdef TIME_HOURS_EN
    ,
    output logic [3:0] hour_ones,
    output logic [3:0] hour_tens
`endif
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   primed;
    logic [2:0]             prime_cnt;
    logic                   tick_edge;
    logic                   advance;
    logic                   so_max;
    logic                   st_max;
    logic                   mo_max;
    logic                   mt_max;
    logic                   wrap_all;

    assign tick_edge = TICK_EDGE ? (sync_q[SYNC_STAGES-1] & ~prev_q)
                                 : (~sync_q[SYNC_STAGES-1] & prev_q);

    // primed waits until both the chain and prev reflect tick_in, so a level
    // already present at reset release is never mistaken for an edge.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            primed     <= 1'b0;
            prime_cnt  <= '0;
            tick_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], tick_in};
            prev_q     <= sync_q[SYNC_STAGES-1];
            tick_pulse <= tick_edge & primed;
            if (!primed) begin
                if (prime_cnt == 3'(SYNC_STAGES))
                    primed <= 1'b1;
                else
                    prime_cnt <= prime_cnt + 3'd1;
            end
        end
    end

    assign advance = tick_pulse & run & ~clear;
    assign so_max  = (sec_ones == 4'd9);
    assign st_max  = (sec_tens == 4'd5);
    assign mo_max  = (min_ones == 4'd9);
    assign mt_max  = (min_tens == 4'd5);

`ifdef TIME_HOURS_EN
    assign wrap_all = so_max & st_max & mo_max & mt_max &
                      (hour_tens == 4'd2) & (hour_ones == 4'd3);
`else
    assign wrap_all = so_max & st_max & mo_max & mt_max;
`endif

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            sec_ones  <= '0;
            sec_tens  <= '0;
            min_ones  <= '0;
            min_tens  <= '0;
            rollover  <= 1'b0;
`ifdef TIME_HOURS_EN
            hour_ones <= '0;
            hour_tens <= '0;
`endif
        end else begin
            rollover <= 1'b0;
            if (clear) begin
                sec_ones  <= '0;
                sec_tens  <= '0;
                min_ones  <= '0;
                min_tens  <= '0;
`ifdef TIME_HOURS_EN
                hour_ones <= '0;
                hour_tens <= '0;
`endif
            end else if (advance) begin
                rollover <= wrap_all;
                sec_ones <= so_max ? 4'd0 : sec_ones + 4'd1;
                if (so_max) begin
                    sec_tens <= st_max ? 4'd0 : sec_tens + 4'd1;
                    if (st_max) begin
                        min_ones <= mo_max ? 4'd0 : min_ones + 4'd1;
                        if (mo_max) begin
                            min_tens <= mt_max ? 4'd0 : min_tens + 4'd1;
`ifdef TIME_HOURS_EN
                            // Hours run 00..23; 23 wraps straight to 00.
                            if (mt_max) begin
                                if (hour_tens == 4'd2 && hour_ones == 4'd3) begin
                                    hour_ones <= 4'd0;
                                    hour_tens <= 4'd0;
                                end else if (hour_ones == 4'd9) begin
                                    hour_ones <= 4'd0;
                                    hour_tens <= hour_tens + 4'd1;
                                end else begin
                                    hour_ones <= hour_ones + 4'd1;
                                end
                            end
`endif
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter in the default MM:SS build (SYNC_STAGES=2, rising edge).
module tb_bcd_time_counter;

    logic       clk_in = 1'b0;
    logic       reset_n;
    logic       tick_in;
    logic       run;
    logic       clear;
    logic       tick_pulse;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       rollover;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int roll_cnt = 0;
    int p0;
    int r0;
    bit seen;

    always #5 clk_in = ~clk_in;

    bcd_time_counter #(.SYNC_STAGES(2), .TICK_EDGE(1'b1)) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .tick_in    (tick_in),
        .run        (run),
        .clear      (clear),
        .tick_pulse (tick_pulse),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .rollover   (rollover)
    );

    always @(negedge clk_in) begin
        if (tick_pulse === 1'b1) pulse_cnt++;
        if (rollover === 1'b1) roll_cnt++;
    end

    function automatic logic [15:0] time_now();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advances one clock; returns just after the falling edge, clear of the active edge.
    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
        #1;
    endtask

    task automatic do_tick();
        tick_in = 1'b1;
        repeat (4) step();
        tick_in = 1'b0;
        repeat (4) step();
    endtask

    task automatic tick_until_pulse(output bit found);
        found = 1'b0;
        tick_in = 1'b1;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (tick_pulse === 1'b1) found = 1'b1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        tick_in = 1'b1;
        run     = 1'b1;
        clear   = 1'b0;
        repeat (5) step();
        check("reset_time", time_now(), 16'h0000);
        check("reset_pulse", tick_pulse, 1'b0);
        check("reset_rollover", rollover, 1'b0);

        // Release with tick_in already high: no false tick.
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("release_pulse", tick_pulse, 1'b0);
            check("release_time", time_now(), 16'h0000);
        end
        tick_in = 1'b0;
        repeat (4) step();
        check("release_pulse_cnt", pulse_cnt, 0);

        // Latency: pulse at k+2, digit update at k+3.
        tick_in = 1'b1;
        step();
        check("lat_k", tick_pulse, 1'b0);
        step();
        check("lat_k1", tick_pulse, 1'b0);
        step();
        check("lat_k2_pulse", tick_pulse, 1'b1);
        check("lat_k2_time", time_now(), 16'h0000);
        step();
        check("lat_k3_pulse", tick_pulse, 1'b0);
        check("lat_k3_time", time_now(), 16'h0001);
        tick_in = 1'b0;
        repeat (4) step();
        check("lat_one_pulse", pulse_cnt, 1);

        // Carries
        repeat (58) do_tick();
        check("carry_0059", time_now(), 16'h0059);
        do_tick();
        check("carry_0100", time_now(), 16'h0100);
        repeat (3599 - 60) do_tick();
        check("carry_5959", time_now(), 16'h5959);
        check("no_early_rollover", roll_cnt, 0);

        // Wrap 59:59 -> 00:00 with a single-cycle rollover.
        tick_until_pulse(seen);
        check("wrap_pulse_seen", seen, 1'b1);
        step();
        check("wrap_time", time_now(), 16'h0000);
        check("wrap_rollover", rollover, 1'b1);
        step();
        check("wrap_rollover_drop", rollover, 1'b0);
        tick_in = 1'b0;
        repeat (4) step();
        check("wrap_roll_cnt", roll_cnt, 1);

        // Hold: pulses continue, digits frozen, nothing replayed.
        run = 1'b0;
        p0 = pulse_cnt;
        repeat (5) do_tick();
        check("hold_pulses", pulse_cnt - p0, 5);
        check("hold_time", time_now(), 16'h0000);
        run = 1'b1;
        do_tick();
        check("resume_time", time_now(), 16'h0001);
        check("resume_pulses", pulse_cnt - p0, 6);

        // Clear colliding with a tick at 12:34.
        repeat (753) do_tick();
        check("pre_clear_1234", time_now(), 16'h1234);
        r0 = roll_cnt;
        tick_until_pulse(seen);
        check("clr_pulse_seen", seen, 1'b1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_time", time_now(), 16'h0000);
        check("clr_rollover", rollover, 1'b0);
        tick_in = 1'b0;
        repeat (4) step();
        check("clr_time_after", time_now(), 16'h0000);
        check("clr_roll_cnt", roll_cnt, r0);

        // Plain clear from a non-zero value.
        repeat (3) do_tick();
        check("pre_clear_0003", time_now(), 16'h0003);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("plain_clear", time_now(), 16'h0000);

        // Reset with an edge in flight: it must be discarded.
        p0 = pulse_cnt;
        tick_in = 1'b1;
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (10) step();
        check("midreset_pulses", pulse_cnt - p0, 0);
        check("midreset_time", time_now(), 16'h0000);
        tick_in = 1'b0;
        repeat (4) step();
        do_tick();
        check("post_reset_tick", time_now(), 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
